// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: sequencer states and
// default sizing.
package mult_pkg;

  localparam int DEFAULT_N     = 32;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/product_register.sv
// Double-width accumulator for the shift-add multiplier. Each step does an
// optional add of the multiplicand into the high half, then a right shift.
module product_register
  import mult_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic           step,
  input  logic [N-1:0]   multiplier_in,
  input  logic [N-1:0]   multiplicand,
  output logic [2*N-1:0] product
);

  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic [N:0]   sum;

  // The carry exists only inside this sum: it is shifted straight into the
  // top of hi, so it never needs a flop of its own.
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, multiplicand} : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (init) begin
      hi <= '0;
      lo <= multiplier_in;
    end else if (step) begin
      hi <= sum[N:1];
      lo <= {sum[0], lo[N-1:1]};
    end
  end

  assign product = {hi, lo};

endmodule

// File: rtl/multiplier_sequencer.sv
// Sequencer for the unsigned shift-add multiplier: loads the Multiplicand
// register, runs N add/shift iterations and hands the product off with valid/ack.
module multiplier_sequencer
  import mult_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplier_in,
  input  logic [N-1:0]   multiplicand_out,
  output logic           w_ctrl_Multiplicand,
  output logic           busy,
  output logic           product_valid,
  input  logic           product_ack,
  output logic [2*N-1:0] product
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             init;
  logic             step;

  assign init = (state == IDLE) && start;
  assign step = (state == CALC);

  product_register #(.N(N)) u_product_register (
    .clk           (clk),
    .rst           (rst),
    .init          (init),
    .step          (step),
    .multiplier_in (multiplier_in),
    .multiplicand  (multiplicand_out),
    .product       (product)
  );

  // The LOAD cycle exists only so the external Multiplicand register is
  // written by the strobe before CALC starts reading it back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      count               <= '0;
      w_ctrl_Multiplicand <= 1'b0;
      busy                <= 1'b0;
      product_valid       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state               <= LOAD;
            count               <= '0;
            w_ctrl_Multiplicand <= 1'b1;
            busy                <= 1'b1;
          end
        end
        LOAD: begin
          w_ctrl_Multiplicand <= 1'b0;
          state               <= CALC;
        end
        CALC: begin
          count <= count + CNT_W'(1);
          if (count == CNT_W'(N - 1)) begin
            state         <= DONE;
            busy          <= 1'b0;
            product_valid <= 1'b1;
          end
        end
        DONE: begin
          if (product_ack) begin
            product_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Bench for multiplier_sequencer: models the external Multiplicand register
// and checks products against plain 64-bit multiplication.
module tb_multiplier_sequencer;

  localparam int N       = 32;
  localparam int LATENCY = N + 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic [N-1:0]    multiplier_in;
  logic [N-1:0]    multiplicand_out;
  logic            w_ctrl_Multiplicand;
  logic            busy;
  logic            product_valid;
  logic            product_ack;
  logic [2*N-1:0]  product;

  logic [N-1:0]    mcand_next;
  int              errors;
  int              checks;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] expected;
  } vec_t;

  vec_t vecs[7];

  multiplier_sequencer #(.N(N)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .multiplier_in       (multiplier_in),
    .multiplicand_out    (multiplicand_out),
    .w_ctrl_Multiplicand (w_ctrl_Multiplicand),
    .busy                (busy),
    .product_valid       (product_valid),
    .product_ack         (product_ack),
    .product             (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External Multiplicand register, written only by the DUT strobe.
  always @(posedge clk or negedge rst) begin
    if (!rst) multiplicand_out <= '0;
    else if (w_ctrl_Multiplicand) multiplicand_out <= mcand_next;
  end

  task automatic checkOutput(input string name, input logic [2*N-1:0] act,
                             input logic [2*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input int pulse_at,
                               output logic [2*N-1:0] got, output int lat,
                               output int busy_cnt, output int strobe_cnt);
    @(negedge clk);
    multiplier_in = a;
    mcand_next    = b;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start         = 1'b0;
    multiplier_in = $urandom;
    lat        = 0;
    busy_cnt   = int'(busy);
    strobe_cnt = int'(w_ctrl_Multiplicand);
    while (!product_valid && lat < 3 * LATENCY) begin
      if (pulse_at != 0 && lat + 1 == pulse_at) begin
        start         = 1'b1;
        product_ack   = 1'b1;
        multiplier_in = ~a;
      end else begin
        start       = 1'b0;
        product_ack = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      busy_cnt   += int'(busy);
      strobe_cnt += int'(w_ctrl_Multiplicand);
    end
    start       = 1'b0;
    product_ack = 1'b0;
    got = product;
  endtask

  task automatic ackProduct();
    @(negedge clk);
    product_ack = 1'b1;
    @(posedge clk);
    #1;
    product_ack = 1'b0;
    checkOutput("valid_after_ack", 64'(product_valid), 64'd0);
  endtask

  task automatic runChecked(input string name, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic [2*N-1:0] exp);
    logic [2*N-1:0] got;
    int lat, bc, sc;
    applyStimulus(a, b, 0, got, lat, bc, sc);
    checkOutput({name, "_product"}, got, exp);
    checkOutput({name, "_latency"}, 64'(lat), 64'(LATENCY));
    checkOutput({name, "_busy_cycles"}, 64'(bc), 64'(LATENCY));
    checkOutput({name, "_strobe_cycles"}, 64'(sc), 64'd1);
    ackProduct();
  endtask

  initial begin
    logic [2*N-1:0] got;
    logic [2*N-1:0] held;
    logic [N-1:0]   ra;
    logic [N-1:0]   rb;
    int lat, bc, sc;

    errors = 0;
    checks = 0;
    vecs[0] = '{32'd3,          32'd5,          64'd15};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,          32'hDEAD_BEEF,  64'd0};
    vecs[3] = '{32'd7,          32'd6,          64'd42};
    vecs[4] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
    vecs[6] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};

    rst = 1'b1;
    start = 1'b0;
    product_ack = 1'b0;
    multiplier_in = '0;
    mcand_next = '0;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_valid", 64'(product_valid), 64'd0);
    checkOutput("reset_strobe", 64'(w_ctrl_Multiplicand), 64'd0);
    checkOutput("reset_product", product, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 3 x 5 with strobe timing and a held (unacknowledged) result.
    @(negedge clk);
    multiplier_in = 32'd3;
    mcand_next    = 32'd5;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("strobe_edge0", 64'(w_ctrl_Multiplicand), 64'd1);
    checkOutput("busy_edge0", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("strobe_edge1", 64'(w_ctrl_Multiplicand), 64'd0);
    repeat (LATENCY - 2) @(posedge clk);
    #1;
    checkOutput("valid_before_33", 64'(product_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("valid_at_33", 64'(product_valid), 64'd1);
    checkOutput("product_3x5", product, 64'd15);
    checkOutput("busy_in_done", 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 64'(product_valid), 64'd1);
      checkOutput("hold_product", product, 64'd15);
    end
    ackProduct();

    // Table of directed vectors.
    for (int i = 0; i < 7; i++) begin
      runChecked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].expected);
    end

    // Random operands against plain multiplication.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      runChecked($sformatf("rand%0d", i), ra, rb, 64'(ra) * 64'(rb));
    end

    // Reset after ten iterations, then a full fresh multiplication.
    @(negedge clk);
    multiplier_in = 32'hFFFF_FFFF;
    mcand_next    = 32'h1234_5678;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_valid", 64'(product_valid), 64'd0);
    checkOutput("midreset_strobe", 64'(w_ctrl_Multiplicand), 64'd0);
    checkOutput("midreset_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    runChecked("after_reset", 32'hCAFE_F00D, 32'h0000_1001,
               64'(32'hCAFE_F00D) * 64'(32'h0000_1001));

    // Start and ack pulsed during CALC must be ignored.
    applyStimulus(32'h1234_5678, 32'd9, 10, got, lat, bc, sc);
    checkOutput("calc_pulse_product", got, 64'h0000_0000_A3D7_0A38);
    checkOutput("calc_pulse_latency", 64'(lat), 64'(LATENCY));
    held = got;
    // Start in DONE without ack: ignored, result held.
    @(negedge clk);
    start = 1'b1;
    multiplier_in = 32'd99;
    @(posedge clk);
    #1;
    checkOutput("done_start_valid", 64'(product_valid), 64'd1);
    checkOutput("done_start_busy", 64'(busy), 64'd0);
    checkOutput("done_start_product", product, held);
    // Ack and start together: ack wins, start ignored this edge.
    @(negedge clk);
    product_ack = 1'b1;
    multiplier_in = 32'd7;
    mcand_next = 32'd6;
    @(posedge clk);
    #1;
    product_ack = 1'b0;
    checkOutput("ack_start_valid", 64'(product_valid), 64'd0);
    checkOutput("ack_start_busy", 64'(busy), 64'd0);
    // Next cycle's start is accepted.
    applyStimulus(32'd7, 32'd6, 0, got, lat, bc, sc);
    checkOutput("second_product", got, 64'd42);
    checkOutput("second_latency", 64'(lat), 64'(LATENCY));
    ackProduct();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
